pwm_demod: RTL and testbench

PWM_DEMOD -- requirements
Module: pwm_demod

---
 rtl/pwm_demod_if.sv | 13 +
 rtl/pwm_demod.sv | 145 ++++++++++++++
 tb/tb_pwm_demod.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_demod_if.sv
// Port bundle for pwm_demod: the PWM stream going in and the recovered duty samples coming out.
interface pwm_demod_if #(
    parameter int N = 10
);
    logic         pwm_in;
    logic [N-1:0] duty_out;
    logic         duty_valid;
    logic         period_err;
    logic         lock;

    modport master (output pwm_in, input duty_out, duty_valid, period_err, lock);
    modport slave  (input pwm_in, output duty_out, duty_valid, period_err, lock);
endinterface

// File: rtl/pwm_demod.sv
// PWM demodulator: measures high time and period of a 2^N-clock PWM stream and reports duty samples.
// Define PWM_DEMOD_GLITCH_FILTER_EN to insert a 3-sample stability filter after the synchronizer.
module pwm_demod #(
    parameter int N = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    pwm_demod_if.slave bus_if
);
    localparam logic [N:0]   PERIOD_NOM = {1'b1, {N{1'b0}}};
    localparam logic [N:0]   PERIOD_MAX = {(N+1){1'b1}};
    localparam logic [N:0]   PERIOD_ONE = {{N{1'b0}}, 1'b1};
    localparam logic [N-1:0] HIGH_MAX   = {N{1'b1}};
    localparam logic [N-1:0] HIGH_ONE   = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    logic sync1_q, sync2_q, prev_q;
    logic cur, rise, fall, timeout;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus_if.pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_DEMOD_GLITCH_FILTER_EN
    logic hist1_q, hist2_q, filt_q;

    // The filtered level only follows the input once three consecutive samples agree.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            if (sync2_q == hist1_q && hist1_q == hist2_q) begin
                filt_q <= sync2_q;
            end
        end
    end

    assign cur = filt_q;
`else
    assign cur = sync2_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= cur;
        end
    end

    assign rise = cur & ~prev_q;
    assign fall = ~cur & prev_q;

    state_e       state_q;
    logic [N-1:0] high_cnt_q;
    logic [N:0]   period_cnt_q;
    logic [1:0]   good_q;
    logic         smp_vld_q, smp_err_q;
    logic [N-1:0] smp_duty_q;

    // A rise on the very cycle the counter saturates still closes the period normally.
    assign timeout = (period_cnt_q == PERIOD_MAX) && !rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            good_q       <= '0;
            smp_vld_q    <= 1'b0;
            smp_err_q    <= 1'b0;
            smp_duty_q   <= '0;
        end else begin
            smp_vld_q <= 1'b0;
            smp_err_q <= 1'b0;
            if (period_cnt_q != PERIOD_MAX) begin
                period_cnt_q <= period_cnt_q + 1'b1;
            end
            if (state_q == HIGH && !fall && high_cnt_q != HIGH_MAX) begin
                high_cnt_q <= high_cnt_q + 1'b1;
            end

            if (rise) begin
                high_cnt_q   <= HIGH_ONE;
                period_cnt_q <= PERIOD_ONE;
                state_q      <= HIGH;
                // The first rise out of IDLE only opens a period; there is nothing to report yet.
                if (state_q != IDLE) begin
                    smp_vld_q  <= 1'b1;
                    smp_duty_q <= high_cnt_q;
                    smp_err_q  <= (period_cnt_q != PERIOD_NOM);
                    if (period_cnt_q != PERIOD_NOM) begin
                        good_q <= 2'd0;
                    end else if (good_q != 2'd2) begin
                        good_q <= good_q + 2'd1;
                    end
                end
            end else if (timeout) begin
                smp_vld_q    <= 1'b1;
                smp_duty_q   <= cur ? HIGH_MAX : '0;
                period_cnt_q <= '0;
                good_q       <= 2'd0;
                state_q      <= IDLE;
            end else if (fall && state_q == HIGH) begin
                state_q <= LOW;
            end
        end
    end

    logic [N-1:0] duty_out_q;
    logic         duty_valid_q, period_err_q, lock_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_out_q   <= '0;
            duty_valid_q <= 1'b0;
            period_err_q <= 1'b0;
            lock_q       <= 1'b0;
        end else begin
            duty_valid_q <= smp_vld_q;
            period_err_q <= smp_vld_q & smp_err_q;
            if (smp_vld_q) begin
                duty_out_q <= smp_duty_q;
                lock_q     <= (good_q == 2'd2);
            end
        end
    end

    assign bus_if.duty_out   = duty_out_q;
    assign bus_if.duty_valid = duty_valid_q;
    assign bus_if.period_err = period_err_q;
    assign bus_if.lock       = lock_q;
endmodule

// File: tb/tb_pwm_demod.sv
// Self-checking bench for pwm_demod: directed scenarios plus random periods, compared every cycle
// against a timestamp-based model of the demodulator's behaviour.
module tb_pwm_demod;
    localparam int N        = 10;
    localparam int NOM      = 1 << N;
    localparam int HMAX     = NOM - 1;
    localparam int TO_FIRST = 2 * NOM - 1;
    localparam int TO_REP   = 2 * NOM;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    pwm_demod_if #(.N(N)) dif ();

    pwm_demod #(.N(N)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus_if (dif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: works from input timestamps (rise/fall clock indices) rather than counters.
    int  cyc;
    bit  vh[4];
    bit  m_filt, m_eprev, m_active;
    int  t_rise, t_fall, deadline, good;
    bit  pend_valid, pend_err, pend_lock;
    int  pend_duty;
    bit  exp_valid, exp_err, exp_lock;
    int  exp_duty;

    // Observations of the DUT, compared against fixed expectations by the directed scenarios.
    int  tcyc, obs_valid, obs_err, last_vcyc, prev_vcyc;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) vh[i] = 1'b0;
        m_filt = 0; m_eprev = 0; m_active = 0;
        t_rise = 0; t_fall = -1; good = 0;
        deadline = cyc + TO_FIRST;
        pend_valid = 0; pend_err = 0; pend_lock = 0; pend_duty = 0;
        exp_valid = 0; exp_err = 0; exp_lock = 0; exp_duty = 0;
    endtask

    task automatic post(input int duty, input bit err);
        pend_valid = 1;
        pend_duty  = duty;
        pend_err   = err;
        pend_lock  = (good >= 2);
    endtask

    task automatic model_edge(input bit val);
        bit e, rise, fall;
        int period, duty;
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
        e = m_filt;
        if (vh[1] == vh[2] && vh[2] == vh[3]) m_filt = vh[1];
`else
        e = vh[1];
`endif
        rise = e && !m_eprev;
        fall = !e && m_eprev;
        exp_valid = pend_valid;
        exp_err   = pend_valid && pend_err;
        if (pend_valid) begin
            exp_duty = pend_duty;
            exp_lock = pend_lock;
        end
        pend_valid = 0;
        if (rise) begin
            if (m_active) begin
                period = cyc - t_rise;
                duty   = (t_fall >= 0) ? t_fall - t_rise : period;
                if (duty > HMAX) duty = HMAX;
                good = (period == NOM) ? ((good < 2) ? good + 1 : 2) : 0;
                post(duty, period != NOM);
            end
            m_active = 1;
            t_rise   = cyc;
            t_fall   = -1;
            deadline = cyc + TO_FIRST;
        end else if (cyc == deadline) begin
            good = 0;
            post(e ? HMAX : 0, 1'b0);
            m_active = 0;
            deadline = cyc + TO_REP;
        end else if (fall && m_active && t_fall < 0) begin
            t_fall = cyc;
        end
        m_eprev = e;
        vh[3] = vh[2]; vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = val;
        cyc++;
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic tick(input bit val);
        dif.pwm_in = val;
        @(posedge clk);
        model_edge(val);
        @(negedge clk);
        tcyc++;
        check("duty_valid", dif.duty_valid, exp_valid);
        check("duty_out", dif.duty_out, exp_duty);
        check("period_err", dif.period_err, exp_err);
        check("lock", dif.lock, exp_lock);
        if (dif.duty_valid) begin
            obs_valid++;
            prev_vcyc = last_vcyc;
            last_vcyc = tcyc;
        end
        if (dif.period_err) obs_err++;
    endtask

    task automatic hold(input bit val, input int n);
        for (int i = 0; i < n; i++) tick(val);
    endtask

    task automatic run_pwm(input int period, input int high, input int reps,
                           input int glitch_at, input int glitch_len);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < period; i++)
                tick(i < high && !(i >= glitch_at && i < glitch_at + glitch_len));
    endtask

    task automatic clear_obs();
        obs_valid = 0; obs_err = 0; last_vcyc = 0; prev_vcyc = 0;
    endtask

    task automatic do_reset(input string tag);
        reset_n    = 1'b0;
        dif.pwm_in = 1'b0;
        model_reset();
        #1;
        check({tag, "_duty_out"}, dif.duty_out, 0);
        check({tag, "_duty_valid"}, dif.duty_valid, 0);
        check({tag, "_period_err"}, dif.period_err, 0);
        check({tag, "_lock"}, dif.lock, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int per, hi, gat, glen;
        cyc = 0; tcyc = 0;
        clear_obs();
        dif.pwm_in = 1'b0;
        #1;
        do_reset("reset");

        // Steady duty 256 at the nominal period: lock after the second sample.
        run_pwm(NOM, 256, 4, -1, 0);
        check("d256_duty", dif.duty_out, 256);
        check("d256_lock", dif.lock, 1);

        // Single low clock per period.
        clear_obs();
        run_pwm(NOM, 1023, 3, -1, 0);
        check("d1023_duty", dif.duty_out, 1023);
        check("d1023_err_count", obs_err, 0);
        check("d1023_lock", dif.lock, 1);

        // Input stuck low: periodic timeout samples of 0, lock dropped.
        clear_obs();
        hold(1'b0, 5000);
        check("stuck_low_count", obs_valid, 2);
        check("stuck_low_interval", last_vcyc - prev_vcyc, TO_REP);
        check("stuck_low_duty", dif.duty_out, 0);
        check("stuck_low_lock", dif.lock, 0);

        // Off-nominal period: every sample flags an error and lock never sets.
        clear_obs();
        run_pwm(1000, 500, 4, -1, 0);
        check("p1000_duty", dif.duty_out, 500);
        check("p1000_err_count", obs_err, 3);
        check("p1000_lock", dif.lock, 0);

        // Reset in the middle of a high phase discards the partial measurement.
        run_pwm(NOM, 300, 2, -1, 0);
        hold(1'b1, 150);
        do_reset("midreset");
        clear_obs();
        hold(1'b0, 50);
        run_pwm(NOM, 300, 1, -1, 0);
        check("midreset_no_early_valid", obs_valid, 0);
        run_pwm(NOM, 300, 2, -1, 0);
        check("midreset_duty", dif.duty_out, 300);

        // One-clock low glitch inside the high phase.
        clear_obs();
        run_pwm(NOM, 600, 4, 300, 1);
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
        check("glitch_err_count", obs_err, 0);
        check("glitch_duty", dif.duty_out, 600);
        check("glitch_lock", dif.lock, 1);
`else
        check("glitch_err_seen", obs_err > 0, 1);
        check("glitch_lock", dif.lock, 0);
`endif

        // Input stuck high: timeout sample reports full scale.
        hold(1'b1, 2500);
        check("stuck_high_duty", dif.duty_out, HMAX);
        check("stuck_high_lock", dif.lock, 0);

        // Random periods, duties and short glitches.
        for (int p = 0; p < 12; p++) begin
            per  = ($urandom_range(1) == 0) ? NOM : int'($urandom_range(1300, 700));
            hi   = int'($urandom_range(per - 1, 1));
            gat  = -1;
            glen = 0;
            if (hi >= 8 && $urandom_range(3) == 0) begin
                gat  = int'($urandom_range(hi - 4, 2));
                glen = int'($urandom_range(2, 1));
            end
            run_pwm(per, hi, 1, gat, glen);
        end
        hold(1'b0, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
